// File: rtl/kbdmus_pkg.sv
// kbdmus_pkg: shared constants for the AVR keyboard/mouse SPI writer.
//   - packet address bytes sent by the AVR
//   - packet payload lengths
//   - deframer FSM state encoding
`timescale 1ns/1ps
package kbdmus_pkg;

    localparam logic [7:0] ADDR_KBD    = 8'h10;
    localparam logic [7:0] ADDR_MUSX   = 8'h20;
    localparam logic [7:0] ADDR_MUSY   = 8'h21;
    localparam logic [7:0] ADDR_MUSBTN = 8'h22;
    localparam logic [7:0] ADDR_KJ     = 8'h23;

    localparam logic [2:0] KBD_LEN  = 3'd5;
    localparam logic [2:0] BYTE_LEN = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDR   = 2'd1,
        ST_DATA   = 2'd2,
        ST_IGNORE = 2'd3
    } state_e;

    // True for the four single-byte mouse/joystick packet addresses.
    function automatic logic is_byte_addr(input logic [7:0] a);
        return (a == ADDR_MUSX) || (a == ADDR_MUSY) ||
               (a == ADDR_MUSBTN) || (a == ADDR_KJ);
    endfunction

endpackage

// File: rtl/spi_bit_rx.sv
// spi_bit_rx: oversampling SPI slave bit receiver in the fclk domain.
// Ports:
//   clk_i, rst_n_i         fclk and synchronous active-low reset
//   spics_n_i, spick_i,    raw asynchronous SPI lines from the AVR
//   spido_i
//   byte_o                 assembled byte, valid while byte_stb_o is high
//   byte_stb_o             one-cycle pulse on the 8th accepted SCK rise
//   cs_o                   synchronized, active-high chip select
`timescale 1ns/1ps
module spi_bit_rx (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       spics_n_i,
    input  logic       spick_i,
    input  logic       spido_i,
    output logic [7:0] byte_o,
    output logic       byte_stb_o,
    output logic       cs_o
);

    // Synchronizers are left unreset so they keep tracking the pins while
    // rst_n is low; the top relies on this to tell a live cs window from a
    // fresh one after reset.
    logic [1:0] cs_n_sync_q;
    logic [1:0] sck_sync_q;
    logic [1:0] do_sync_q;
    logic       sck_prev_q;

    always_ff @(posedge clk_i) begin
        cs_n_sync_q <= {cs_n_sync_q[0], spics_n_i};
        sck_sync_q  <= {sck_sync_q[0],  spick_i};
        do_sync_q   <= {do_sync_q[0],   spido_i};
        sck_prev_q  <= sck_sync_q[1];
    end

    logic cs;
    logic accept;

    assign cs     = ~cs_n_sync_q[1];
    assign accept = cs & sck_sync_q[1] & ~sck_prev_q;

    // Only 7 bits are stored: the 8th bit of a byte is taken live from the
    // synchronizer in the completing cycle.
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [6:0] shift_q,  shift_d;

    always_comb begin
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        if (!cs) begin
            bitcnt_d = 3'd0;
        end else if (accept) begin
            bitcnt_d = bitcnt_q + 3'd1;
            shift_d  = {shift_q[5:0], do_sync_q[1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            bitcnt_q <= 3'd0;
            shift_q  <= 7'd0;
        end else begin
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
        end
    end

    assign byte_o     = {shift_q, do_sync_q[1]};
    assign byte_stb_o = accept && (bitcnt_q == 3'd7);
    assign cs_o       = cs;

endmodule

// File: rtl/kbdmus_spi_writer.sv
// kbdmus_spi_writer: deframes AVR SPI packets (address byte + payload) into
// the keyboard matrix word and mouse/joystick byte with one-cycle strobes.
// Ports:
//   fclk, rst_n                       clock, synchronous active-low reset
//   spics_n, spick, spido             asynchronous SPI slave inputs
//   kbd_out[39:0], kbd_stb            keyboard word and its update pulse
//   mus_out[7:0]                      mouse/joystick payload byte
//   mus_xstb, mus_ystb, mus_btnstb,   which kind of byte mus_out holds
//   kj_stb
`timescale 1ns/1ps
module kbdmus_spi_writer
    import kbdmus_pkg::*;
(
    input  logic        fclk,
    input  logic        rst_n,
    input  logic        spics_n,
    input  logic        spick,
    input  logic        spido,
    output logic [39:0] kbd_out,
    output logic        kbd_stb,
    output logic [7:0]  mus_out,
    output logic        mus_xstb,
    output logic        mus_ystb,
    output logic        mus_btnstb,
    output logic        kj_stb
);

    logic [7:0] rx_byte;
    logic       rx_stb;
    logic       cs;

    spi_bit_rx u_rx (
        .clk_i      (fclk),
        .rst_n_i    (rst_n),
        .spics_n_i  (spics_n),
        .spick_i    (spick),
        .spido_i    (spido),
        .byte_o     (rx_byte),
        .byte_stb_o (rx_stb),
        .cs_o       (cs)
    );

    state_e      state_q, state_d;
    logic [2:0]  len_q,   len_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic [7:0]  addr_q,  addr_d;
    // First four keyboard bytes; the fifth is appended live at commit.
    logic [31:0] stage_q, stage_d;
    logic [39:0] kbd_q,   kbd_d;
    logic [7:0]  mus_q,   mus_d;
    logic        kbd_stb_q, kbd_stb_d;
    logic        xstb_q,    xstb_d;
    logic        ystb_q,    ystb_d;
    logic        btnstb_q,  btnstb_d;
    logic        kjstb_q,   kjstb_d;
    // Previous cs; resets to 1 so a cs window already open at reset release
    // is not mistaken for a new packet.
    logic        cs_prev_q;
    logic [2:0]  cnt_inc;

    assign cnt_inc = cnt_q + 3'd1;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        stage_d   = stage_q;
        kbd_d     = kbd_q;
        mus_d     = mus_q;
        kbd_stb_d = 1'b0;
        xstb_d    = 1'b0;
        ystb_d    = 1'b0;
        btnstb_d  = 1'b0;
        kjstb_d   = 1'b0;

        if (!cs) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!cs_prev_q) begin
                        state_d = ST_ADDR;
                        cnt_d   = 3'd0;
                    end
                end
                ST_ADDR: begin
                    if (rx_stb) begin
                        addr_d = rx_byte;
                        cnt_d  = 3'd0;
                        if (rx_byte == ADDR_KBD) begin
                            state_d = ST_DATA;
                            len_d   = KBD_LEN;
                        end else if (is_byte_addr(rx_byte)) begin
                            state_d = ST_DATA;
                            len_d   = BYTE_LEN;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_stb) begin
                        stage_d = {stage_q[23:0], rx_byte};
                        cnt_d   = cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_d = ST_IGNORE;
                            if (addr_q == ADDR_KBD) begin
                                kbd_d     = {stage_q, rx_byte};
                                kbd_stb_d = 1'b1;
                            end else begin
                                mus_d = rx_byte;
                                case (addr_q)
                                    ADDR_MUSX:   xstb_d   = 1'b1;
                                    ADDR_MUSY:   ystb_d   = 1'b1;
                                    ADDR_MUSBTN: btnstb_d = 1'b1;
                                    default:     kjstb_d  = 1'b1;
                                endcase
                            end
                        end
                    end
                end
                default: ; // ST_IGNORE: wait for cs to drop
            endcase
        end
    end

    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            len_q     <= 3'd0;
            cnt_q     <= 3'd0;
            addr_q    <= 8'h00;
            stage_q   <= 32'd0;
            kbd_q     <= 40'd0;
            mus_q     <= 8'h00;
            kbd_stb_q <= 1'b0;
            xstb_q    <= 1'b0;
            ystb_q    <= 1'b0;
            btnstb_q  <= 1'b0;
            kjstb_q   <= 1'b0;
            cs_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            stage_q   <= stage_d;
            kbd_q     <= kbd_d;
            mus_q     <= mus_d;
            kbd_stb_q <= kbd_stb_d;
            xstb_q    <= xstb_d;
            ystb_q    <= ystb_d;
            btnstb_q  <= btnstb_d;
            kjstb_q   <= kjstb_d;
            cs_prev_q <= cs;
        end
    end

    assign kbd_out    = kbd_q;
    assign kbd_stb    = kbd_stb_q;
    assign mus_out    = mus_q;
    assign mus_xstb   = xstb_q;
    assign mus_ystb   = ystb_q;
    assign mus_btnstb = btnstb_q;
    assign kj_stb     = kjstb_q;

endmodule

// File: tb/tb_kbdmus_spi_writer.sv
`timescale 1ns/1ps
module tb_kbdmus_spi_writer;

    logic        fclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spics_n = 1'b1;
    logic        spick = 1'b0;
    logic        spido = 1'b0;
    logic [39:0] kbd_out;
    logic        kbd_stb;
    logic [7:0]  mus_out;
    logic        mus_xstb, mus_ystb, mus_btnstb, kj_stb;

    kbdmus_spi_writer dut (
        .fclk       (fclk),
        .rst_n      (rst_n),
        .spics_n    (spics_n),
        .spick      (spick),
        .spido      (spido),
        .kbd_out    (kbd_out),
        .kbd_stb    (kbd_stb),
        .mus_out    (mus_out),
        .mus_xstb   (mus_xstb),
        .mus_ystb   (mus_ystb),
        .mus_btnstb (mus_btnstb),
        .kj_stb     (kj_stb)
    );

    always #5 fclk = ~fclk;

    int n_tests = 0;
    int n_fail  = 0;

    // strobe monitor
    int          cyc = 0;
    int          rise_cyc = 0;
    int          stb_cyc = 0;
    int          n_kbd = 0, n_x = 0, n_y = 0, n_btn = 0, n_kj = 0, n_multi = 0;
    logic [7:0]  last_mus = 8'h00;
    logic [39:0] last_kbd = 40'd0;

    always @(posedge fclk) cyc <= cyc + 1;

    always @(negedge fclk) begin
        if ($countones({kbd_stb, mus_xstb, mus_ystb, mus_btnstb, kj_stb}) > 1)
            n_multi = n_multi + 1;
        if (kbd_stb) begin n_kbd = n_kbd + 1; last_kbd = kbd_out; stb_cyc = cyc; end
        if (mus_xstb)   begin n_x   = n_x + 1;   last_mus = mus_out; stb_cyc = cyc; end
        if (mus_ystb)   begin n_y   = n_y + 1;   last_mus = mus_out; stb_cyc = cyc; end
        if (mus_btnstb) begin n_btn = n_btn + 1; last_mus = mus_out; stb_cyc = cyc; end
        if (kj_stb)     begin n_kj  = n_kj + 1;  last_mus = mus_out; stb_cyc = cyc; end
    end

    int s_kbd, s_x, s_y, s_btn, s_kj;
    task automatic snap;
        s_kbd = n_kbd; s_x = n_x; s_y = n_y; s_btn = n_btn; s_kj = n_kj;
    endtask

    logic [7:0] pkt[$];

    task automatic spi_bit(input logic b);
        @(posedge fclk); #1;
        spido = b;
        spick = 1'b0;
        repeat (4) @(posedge fclk);
        #1;
        spick = 1'b1;
        rise_cyc = cyc;
        repeat (5) @(posedge fclk);
    endtask

    task automatic spi_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) spi_bit(v[i]);
    endtask

    task automatic cs_open;
        @(posedge fclk); #1;
        spics_n = 1'b0;
        repeat (6) @(posedge fclk);
    endtask

    task automatic cs_close;
        @(posedge fclk); #1;
        spick = 1'b0;
        repeat (4) @(posedge fclk);
        #1;
        spics_n = 1'b1;
        repeat (6) @(posedge fclk);
        #1;
    endtask

    task automatic send_pkt;
        cs_open();
        foreach (pkt[i]) spi_byte(pkt[i]);
        cs_close();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (5) @(posedge fclk);
        #1;
        n_tests++;
        if (kbd_out !== 40'd0) begin n_fail++; $display("FAIL reset_kbd_out got %h exp 0", kbd_out); end
        n_tests++;
        if (mus_out !== 8'h00) begin n_fail++; $display("FAIL reset_mus_out got %h exp 0", mus_out); end
        n_tests++;
        if ({kbd_stb, mus_xstb, mus_ystb, mus_btnstb, kj_stb} !== 5'b0) begin
            n_fail++; $display("FAIL reset_strobes got %b exp 00000",
                               {kbd_stb, mus_xstb, mus_ystb, mus_btnstb, kj_stb});
        end
        rst_n = 1'b1;
        repeat (3) @(posedge fclk);
    endtask

    task automatic test_kbd;
        snap();
        pkt = '{8'h10, 8'h01, 8'h02, 8'h04, 8'h08, 8'h80};
        send_pkt();
        n_tests++;
        if (n_kbd - s_kbd !== 1) begin n_fail++; $display("FAIL kbd_stb_count got %0d exp 1", n_kbd - s_kbd); end
        n_tests++;
        if (last_kbd !== 40'h0102040880) begin n_fail++; $display("FAIL kbd_word got %h exp 0102040880", last_kbd); end
        n_tests++;
        if (kbd_out !== 40'h0102040880) begin n_fail++; $display("FAIL kbd_hold got %h exp 0102040880", kbd_out); end
        n_tests++;
        if ((n_x - s_x) + (n_y - s_y) + (n_btn - s_btn) + (n_kj - s_kj) !== 0) begin
            n_fail++; $display("FAIL kbd_no_mus got %0d exp 0", (n_x - s_x) + (n_y - s_y) + (n_btn - s_btn) + (n_kj - s_kj));
        end
    endtask

    task automatic test_mus;
        logic [7:0] addrs[4];
        logic [7:0] vals[4];
        addrs = '{8'h20, 8'h21, 8'h22, 8'h23};
        vals  = '{8'h7F, 8'h81, 8'hFA, 8'h1F};
        for (int k = 0; k < 4; k++) begin
            snap();
            pkt = '{addrs[k], vals[k]};
            send_pkt();
            n_tests++;
            if ((n_x - s_x) !== (k == 0 ? 1 : 0) || (n_y - s_y) !== (k == 1 ? 1 : 0) ||
                (n_btn - s_btn) !== (k == 2 ? 1 : 0) || (n_kj - s_kj) !== (k == 3 ? 1 : 0) ||
                (n_kbd - s_kbd) !== 0) begin
                n_fail++;
                $display("FAIL mus_strobe_%0d got x%0d y%0d b%0d j%0d k%0d exp only index %0d",
                         k, n_x - s_x, n_y - s_y, n_btn - s_btn, n_kj - s_kj, n_kbd - s_kbd, k);
            end
            n_tests++;
            if (last_mus !== vals[k]) begin n_fail++; $display("FAIL mus_byte_%0d got %h exp %h", k, last_mus, vals[k]); end
            if (k == 0) begin
                n_tests++;
                if (stb_cyc - rise_cyc !== 3) begin
                    n_fail++; $display("FAIL latency got %0d exp 3", stb_cyc - rise_cyc);
                end
            end
        end
    endtask

    task automatic test_abort;
        snap();
        pkt = '{8'h10, 8'h11, 8'h22, 8'h33};
        send_pkt();
        n_tests++;
        if (n_kbd - s_kbd !== 0) begin n_fail++; $display("FAIL abort_stb got %0d exp 0", n_kbd - s_kbd); end
        n_tests++;
        if (kbd_out !== 40'h0102040880) begin n_fail++; $display("FAIL abort_hold got %h exp 0102040880", kbd_out); end
        snap();
        pkt = '{8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h55};
        send_pkt();
        n_tests++;
        if (n_kbd - s_kbd !== 1) begin n_fail++; $display("FAIL abort_next_stb got %0d exp 1", n_kbd - s_kbd); end
        n_tests++;
        if (kbd_out !== 40'hDEADBEEF55) begin n_fail++; $display("FAIL abort_next_word got %h exp deadbeef55", kbd_out); end
    endtask

    task automatic test_ignore;
        snap();
        pkt = '{8'h55, 8'hAA, 8'hBB};
        send_pkt();
        n_tests++;
        if ((n_kbd - s_kbd) + (n_x - s_x) + (n_y - s_y) + (n_btn - s_btn) + (n_kj - s_kj) !== 0) begin
            n_fail++; $display("FAIL bad_addr_strobes got %0d exp 0",
                               (n_kbd - s_kbd) + (n_x - s_x) + (n_y - s_y) + (n_btn - s_btn) + (n_kj - s_kj));
        end
        snap();
        pkt = '{8'h20, 8'h05};
        send_pkt();
        n_tests++;
        if (n_x - s_x !== 1 || last_mus !== 8'h05) begin
            n_fail++; $display("FAIL after_bad_x got cnt %0d byte %h exp cnt 1 byte 05", n_x - s_x, last_mus);
        end
    endtask

    task automatic test_extra_byte;
        snap();
        pkt = '{8'h21, 8'h3C, 8'h99};
        send_pkt();
        n_tests++;
        if (n_y - s_y !== 1 || (n_x - s_x) + (n_btn - s_btn) + (n_kj - s_kj) + (n_kbd - s_kbd) !== 0) begin
            n_fail++; $display("FAIL extra_strobes got y%0d others %0d exp y1 others 0",
                               n_y - s_y, (n_x - s_x) + (n_btn - s_btn) + (n_kj - s_kj) + (n_kbd - s_kbd));
        end
        n_tests++;
        if (mus_out !== 8'h3C) begin n_fail++; $display("FAIL extra_hold got %h exp 3c", mus_out); end
    endtask

    task automatic test_mid_reset;
        snap();
        cs_open();
        spi_byte(8'h10);
        spi_byte(8'h11);
        spi_byte(8'h22);
        for (int i = 7; i >= 4; i--) spi_bit(8'h33 >> i);
        @(posedge fclk); #1;
        rst_n = 1'b0;
        @(posedge fclk); #1;
        n_tests++;
        if (kbd_out !== 40'd0 || mus_out !== 8'h00 ||
            {kbd_stb, mus_xstb, mus_ystb, mus_btnstb, kj_stb} !== 5'b0) begin
            n_fail++; $display("FAIL midrst_outputs got kbd %h mus %h exp 0 0", kbd_out, mus_out);
        end
        rst_n = 1'b1;
        for (int i = 3; i >= 0; i--) spi_bit(8'h33 >> i);
        spi_byte(8'h44);
        spi_byte(8'h55);
        spi_byte(8'h66);
        cs_close();
        n_tests++;
        if (n_kbd - s_kbd !== 0 || kbd_out !== 40'd0) begin
            n_fail++; $display("FAIL midrst_window got cnt %0d kbd %h exp 0 0", n_kbd - s_kbd, kbd_out);
        end
        snap();
        pkt = '{8'h10, 8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'h0F};
        send_pkt();
        n_tests++;
        if (n_kbd - s_kbd !== 1 || kbd_out !== 40'hA55AC33C0F) begin
            n_fail++; $display("FAIL midrst_fresh got cnt %0d kbd %h exp 1 a55ac33c0f", n_kbd - s_kbd, kbd_out);
        end
    endtask

    task automatic test_exclusive;
        n_tests++;
        if (n_multi !== 0) begin n_fail++; $display("FAIL strobe_exclusive got %0d exp 0", n_multi); end
    endtask

    initial begin
        test_reset();
        test_kbd();
        test_mus();
        test_abort();
        test_ignore();
        test_extra_byte();
        test_mid_reset();
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
